// File: rtl/taiga_types.sv
// +----------------------------------------------------------------------------+
// | taiga_types: shared client IDs, L2 scheduler constants and request struct. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package taiga_types;

  localparam int L1_ICACHE_ID = 0;
  localparam int L1_DCACHE_ID = 1;
  localparam int L1_IMMU_ID   = 2;
  localparam int L1_DMMU_ID   = 3;

  localparam int L2_SCHED_NUM_REQ         = L1_DMMU_ID + 1;
  localparam int L2_SCHED_MAX_OUTSTANDING = 2;
  localparam int L2_SCHED_BURST_W         = 5;
  localparam int L2_SCHED_ID_W            = $clog2(L2_SCHED_NUM_REQ);

  typedef struct packed {
    logic [29:0]                   addr;
    logic                          rnw;
    logic [3:0]                    be;
    logic [31:0]                   wdata;
    logic [L2_SCHED_BURST_W-1:0]   burst_len;
    logic [L2_SCHED_ID_W-1:0]      id;
  } l2_sched_req_t;

endpackage

`default_nettype wire

// File: rtl/round_robin_picker.sv
// +----------------------------------------------------------------------------+
// | round_robin_picker: combinational first-eligible-at-or-after-pointer pick. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module round_robin_picker #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [ID_W-1:0]    i_pointer,
  input  logic               i_load,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_grant_valid
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_found       = 1'b0;
    w_idx         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = (int'(i_pointer) + off) % NUM_REQ;
      if (!w_found && i_eligible[w_idx]) begin
        w_found            = 1'b1;
        o_grant[w_idx]     = i_load;
        o_grant_idx        = ID_W'(w_idx);
        o_grant_valid      = i_load;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_request_scheduler.sv
// +----------------------------------------------------------------------------+
// | l2_request_scheduler: round-robin share of the L2 port among L1 clients,   |
// | one-entry output register, per-client read tracking and response routing. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module l2_request_scheduler
  import taiga_types::*;
#(
  parameter  int NUM_REQ         = L2_SCHED_NUM_REQ,
  parameter  int MAX_OUTSTANDING = L2_SCHED_MAX_OUTSTANDING,
  parameter  int BURST_W         = L2_SCHED_BURST_W,
  localparam int ID_W            = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*30-1:0]   i_req_addr,
  input  logic [NUM_REQ-1:0]      i_req_rnw,
  input  logic [NUM_REQ*4-1:0]    i_req_be,
  input  logic [NUM_REQ*32-1:0]   i_req_wdata,
  input  logic [NUM_REQ*BURST_W-1:0] i_req_burst_len,
  output logic                    o_l2_req_valid,
  input  logic                    i_l2_req_ready,
  output logic [29:0]             o_l2_addr,
  output logic                    o_l2_rnw,
  output logic [3:0]              o_l2_be,
  output logic [31:0]             o_l2_wdata,
  output logic [BURST_W-1:0]      o_l2_burst_len,
  output logic [ID_W-1:0]         o_l2_req_id,
  input  logic                    i_l2_rd_valid,
  input  logic [31:0]             i_l2_rd_data,
  input  logic [ID_W-1:0]         i_l2_rd_id,
  input  logic                    i_l2_rd_last,
  output logic [NUM_REQ-1:0]      o_rsp_valid,
  output logic [31:0]             o_rsp_data,
  output logic                    o_rsp_last,
  output logic                    o_protocol_error
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  l2_sched_req_t r_held;
  l2_sched_req_t w_next_req;
  logic [ID_W-1:0] r_ptr;
  logic            r_err;

  logic            w_load;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_valid;
  logic [NUM_REQ-1:0] w_rd_hit;
  logic [NUM_REQ-1:0] w_underflow;
  logic               w_id_bad;

  assign w_load = (r_state == S_EMPTY) | i_l2_req_ready;

  round_robin_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_eligible    (w_eligible),
    .i_pointer     (r_ptr),
    .i_load        (w_load),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  // Nothing is handed to a client while reset is held, even though the
  // empty state would otherwise offer a load slot.
  assign o_req_ready = w_grant & {NUM_REQ{rst_n}};

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_client
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_rd_hit[gi]    = i_l2_rd_valid & (i_l2_rd_id == ID_W'(gi));
    assign w_inc           = w_grant[gi] & i_req_rnw[gi];
    assign w_dec           = w_rd_hit[gi] & i_l2_rd_last & (r_cnt != '0);
    assign w_underflow[gi] = w_rd_hit[gi] & i_l2_rd_last & (r_cnt == '0);
    assign w_eligible[gi]  = i_req_valid[gi] & (~i_req_rnw[gi] | (r_cnt < C_CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign w_id_bad = i_l2_rd_valid & ~(|w_rd_hit);

  always_comb begin
    w_next_req           = '0;
    w_next_req.addr      = i_req_addr[int'(w_grant_idx)*30 +: 30];
    w_next_req.rnw       = i_req_rnw[w_grant_idx];
    w_next_req.be        = i_req_be[int'(w_grant_idx)*4 +: 4];
    w_next_req.wdata     = i_req_wdata[int'(w_grant_idx)*32 +: 32];
    w_next_req.burst_len = i_req_burst_len[int'(w_grant_idx)*BURST_W +: BURST_W];
    w_next_req.id        = w_grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    o_l2_req_valid = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_grant_valid) w_state_next = S_HELD;
      end
      S_HELD: begin
        o_l2_req_valid = 1'b1;
        if (i_l2_req_ready && !w_grant_valid) w_state_next = S_EMPTY;
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= '0;
      r_ptr  <= '0;
    end else if (w_grant_valid) begin
      r_held <= w_next_req;
      r_ptr  <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_id_bad || (|w_underflow)) begin
      r_err <= 1'b1;
    end
  end

  assign o_l2_addr        = r_held.addr;
  assign o_l2_rnw         = r_held.rnw;
  assign o_l2_be          = r_held.be;
  assign o_l2_wdata       = r_held.wdata;
  assign o_l2_burst_len   = r_held.burst_len;
  assign o_l2_req_id      = r_held.id;
  assign o_rsp_valid      = w_rd_hit;
  assign o_rsp_data       = i_l2_rd_data;
  assign o_rsp_last       = i_l2_rd_last;
  assign o_protocol_error = r_err;

endmodule

`default_nettype wire

// File: tb/tb_l2_request_scheduler.sv
// Directed bench for l2_request_scheduler: vector table plus multi-cycle sequences.
`default_nettype none

module tb_l2_request_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   i_req_valid;
  logic [3:0]   o_req_ready;
  logic [119:0] i_req_addr;
  logic [3:0]   i_req_rnw;
  logic [15:0]  i_req_be;
  logic [127:0] i_req_wdata;
  logic [19:0]  i_req_burst_len;
  logic         o_l2_req_valid;
  logic         i_l2_req_ready;
  logic [29:0]  o_l2_addr;
  logic         o_l2_rnw;
  logic [3:0]   o_l2_be;
  logic [31:0]  o_l2_wdata;
  logic [4:0]   o_l2_burst_len;
  logic [1:0]   o_l2_req_id;
  logic         i_l2_rd_valid;
  logic [31:0]  i_l2_rd_data;
  logic [1:0]   i_l2_rd_id;
  logic         i_l2_rd_last;
  logic [3:0]   o_rsp_valid;
  logic [31:0]  o_rsp_data;
  logic         o_rsp_last;
  logic         o_protocol_error;

  int checks = 0;
  int errors = 0;

  l2_request_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (i_req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_addr       (i_req_addr),
    .i_req_rnw        (i_req_rnw),
    .i_req_be         (i_req_be),
    .i_req_wdata      (i_req_wdata),
    .i_req_burst_len  (i_req_burst_len),
    .o_l2_req_valid   (o_l2_req_valid),
    .i_l2_req_ready   (i_l2_req_ready),
    .o_l2_addr        (o_l2_addr),
    .o_l2_rnw         (o_l2_rnw),
    .o_l2_be          (o_l2_be),
    .o_l2_wdata       (o_l2_wdata),
    .o_l2_burst_len   (o_l2_burst_len),
    .o_l2_req_id      (o_l2_req_id),
    .i_l2_rd_valid    (i_l2_rd_valid),
    .i_l2_rd_data     (i_l2_rd_data),
    .i_l2_rd_id       (i_l2_rd_id),
    .i_l2_rd_last     (i_l2_rd_last),
    .o_rsp_valid      (o_rsp_valid),
    .o_rsp_data       (o_rsp_data),
    .o_rsp_last       (o_rsp_last),
    .o_protocol_error (o_protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] rnw;
    logic       l2rdy;
    logic       rdv;
    logic [1:0] rdid;
    logic       rdlast;
    logic [3:0] exp_ready;
    logic [3:0] exp_rsp;
    logic       exp_v;
    logic [1:0] exp_id;
    logic       exp_err;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rv, input logic [3:0] rnw, input logic rdy,
                       input logic rdv, input logic [1:0] rdid, input logic rdlast);
    i_req_valid    = rv;
    i_req_rnw      = rnw;
    i_l2_req_ready = rdy;
    i_l2_rd_valid  = rdv;
    i_l2_rd_id     = rdid;
    i_l2_rd_last   = rdlast;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      i_req_addr[i*30 +: 30]    = 30'(256 + i);
      i_req_be[i*4 +: 4]        = 4'(i + 3);
      i_req_wdata[i*32 +: 32]   = 32'hCAFE_0000 + 32'(i);
      i_req_burst_len[i*5 +: 5] = 5'(i + 1);
    end
    i_l2_rd_data = 32'h0;

    //          rv    rnw   rdy  rdv  id    last  ready  rsp   v     id    err
    vecs[0]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0};
    vecs[1]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h2, 4'h0, 1'b1, 2'd1, 1'b0};
    vecs[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h4, 4'h0, 1'b1, 2'd2, 1'b0};
    vecs[3]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h8, 4'h0, 1'b1, 2'd3, 1'b0};
    vecs[4]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0};
    vecs[5]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h2, 4'h0, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h4, 4'h0, 1'b1, 2'd2, 1'b0};
    vecs[7]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h8, 4'h0, 1'b1, 2'd3, 1'b0};
    vecs[8]  = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
    vecs[9]  = '{4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0, 4'h4, 1'b0, 2'd0, 1'b0};
    vecs[10] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h4, 4'h0, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{4'h2, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd2, 1'b0};
    vecs[12] = '{4'h2, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h2, 4'h0, 1'b1, 2'd1, 1'b0};
    vecs[13] = '{4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1, 1'b0};
    vecs[14] = '{4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0};
    vecs[15] = '{4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 1'b0};
    vecs[16] = '{4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0, 4'h1, 1'b0, 2'd0, 1'b1};
    vecs[18] = '{4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 4'h2, 1'b0, 2'd0, 1'b1};
    vecs[19] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h1, 4'h0, 1'b1, 2'd0, 1'b1};

    // Reset state
    drive(4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("reset_l2_valid", 32'(o_l2_req_valid), 32'h0);
    chk("reset_req_ready", 32'(o_req_ready), 32'h0);
    chk("reset_l2_addr", 32'(o_l2_addr), 32'h0);
    chk("reset_err", 32'(o_protocol_error), 32'h0);
    do_reset();

    // Table
    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].rv, vecs[k].rnw, vecs[k].l2rdy, vecs[k].rdv, vecs[k].rdid, vecs[k].rdlast);
      i_l2_rd_data = 32'hD000_0000 + 32'(k);
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready", k), 32'(o_req_ready), 32'(vecs[k].exp_ready));
      chk($sformatf("vec%0d_rsp_valid", k), 32'(o_rsp_valid), 32'(vecs[k].exp_rsp));
      if (vecs[k].rdv)
        chk($sformatf("vec%0d_rsp_data", k), o_rsp_data, 32'hD000_0000 + 32'(k));
      next_cycle();
      chk($sformatf("vec%0d_l2_valid", k), 32'(o_l2_req_valid), 32'(vecs[k].exp_v));
      if (vecs[k].exp_v) begin
        chk($sformatf("vec%0d_l2_id", k), 32'(o_l2_req_id), 32'(vecs[k].exp_id));
        chk($sformatf("vec%0d_l2_addr", k), 32'(o_l2_addr), 32'(256 + int'(vecs[k].exp_id)));
      end
      chk($sformatf("vec%0d_err", k), 32'(o_protocol_error), 32'(vecs[k].exp_err));
    end

    // Write stalled by L2 for 5 cycles: payload holds, nobody else is accepted
    do_reset();
    drive(4'h2, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("stall_grant", 32'(o_req_ready), 32'h2);
    next_cycle();
    drive(4'h1, 4'h1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), 32'(o_l2_req_valid), 32'h1);
      chk($sformatf("stall%0d_ready", c), 32'(o_req_ready), 32'h0);
      chk($sformatf("stall%0d_addr", c), 32'(o_l2_addr), 32'd257);
      chk($sformatf("stall%0d_wdata", c), o_l2_wdata, 32'hCAFE_0001);
      chk($sformatf("stall%0d_be", c), 32'(o_l2_be), 32'h4);
      chk($sformatf("stall%0d_rnw", c), 32'(o_l2_rnw), 32'h0);
      chk($sformatf("stall%0d_id", c), 32'(o_l2_req_id), 32'h1);
      next_cycle();
    end
    drive(4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    next_cycle();
    chk("stall_drain_valid", 32'(o_l2_req_valid), 32'h0);

    // Burst back to client 3 while client 3 is granted another read
    do_reset();
    drive(4'h8, 4'h8, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("burst_first_grant", 32'(o_req_ready), 32'h8);
    next_cycle();
    chk("burst_first_len", 32'(o_l2_burst_len), 32'h4);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) drive(4'h8, 4'h8, 1'b1, 1'b1, 2'd3, 1'b1);
      else        drive(4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0);
      i_l2_rd_data = 32'hB000_0000 + 32'(b);
      @(negedge clk);
      chk($sformatf("beat%0d_rsp_valid", b), 32'(o_rsp_valid), 32'h8);
      chk($sformatf("beat%0d_rsp_data", b), o_rsp_data, 32'hB000_0000 + 32'(b));
      chk($sformatf("beat%0d_rsp_last", b), 32'(o_rsp_last), (b == 3) ? 32'h1 : 32'h0);
      if (b == 3) chk("beat_last_grant", 32'(o_req_ready), 32'h8);
      next_cycle();
    end
    drive(4'h8, 4'h8, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("burst_cnt_one_grant", 32'(o_req_ready), 32'h8);
    next_cycle();
    @(negedge clk);
    chk("burst_cnt_full_block", 32'(o_req_ready), 32'h0);
    chk("burst_err", 32'(o_protocol_error), 32'h0);
    next_cycle();

    // Reset while holding a request with outstanding reads {1,2,0,1}
    do_reset();
    drive(4'h1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0); next_cycle();
    drive(4'h2, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0); next_cycle();
    drive(4'h2, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_second_read_c1", 32'(o_req_ready), 32'h2);
    next_cycle();
    drive(4'h8, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0); next_cycle();
    drive(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0); next_cycle();
    chk("pre_rst_held", 32'(o_l2_req_valid), 32'h1);
    drive(4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(o_l2_req_valid), 32'h0);
    chk("async_rst_ready", 32'(o_req_ready), 32'h0);
    chk("async_rst_id", 32'(o_l2_req_id), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_first_grant", 32'(o_req_ready), 32'h1);
    next_cycle();
    drive(4'h2, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("post_rst_c1_read_a", 32'(o_req_ready), 32'h2);
    next_cycle();
    @(negedge clk);
    chk("post_rst_c1_read_b", 32'(o_req_ready), 32'h2);
    next_cycle();
    drive(4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1);
    next_cycle();
    chk("post_rst_stale_last_err", 32'(o_protocol_error), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l2_request_scheduler.md
Name: l2_request_scheduler

Overview:
- Shares the single L2 requester port between the core's L1 clients: icache, dcache, instruction MMU and data MMU.
- Performs round-robin arbitration and holds the granted request in a one-entry output register until L2 accepts it.
- Tracks outstanding reads per client and routes read-data beats back to the issuing client by ID.
- Sits between the L1 clients and the core's L2 port.

Parameters:
- NUM_REQ, 4, number of L1 clients (ID 0..NUM_REQ-1).
- MAX_OUTSTANDING, 2, maximum unretired reads per client.
- BURST_W, 5, width of the burst-length field (beats-1).
- ID_W (localparam), $clog2(NUM_REQ), width of the requester-ID field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-client request valid.
- req_ready  out  NUM_REQ  per-client request accepted this cycle.
- req_addr  in  NUM_REQ x 30  word address.
- req_rnw  in  NUM_REQ  1 = read, 0 = write.
- req_be  in  NUM_REQ x 4  byte enables (writes).
- req_wdata  in  NUM_REQ x 32  write data (single-beat writes only).
- req_burst_len  in  NUM_REQ x BURST_W  read beats-1.
- l2_req_valid  out  1  request held for L2.
- l2_req_ready  in  1  L2 accepts the held request.
- l2_addr  out  30
- l2_rnw  out  1
- l2_be  out  4
- l2_wdata  out  32
- l2_burst_len  out  BURST_W
- l2_req_id  out  ID_W  ID of the originating client.
- l2_rd_valid  in  1  read beat valid.
- l2_rd_data  in  32
- l2_rd_id  in  ID_W
- l2_rd_last  in  1  final beat of a burst.
- rsp_valid  out  NUM_REQ  one-hot routed beat valid.
- rsp_data  out  32  broadcast read data.
- rsp_last  out  1  broadcast last flag.
- protocol_error  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - Held register empties; l2_req_valid=0 and all l2_* payload fields=0.
  - Round-robin pointer is set so client 0 has first priority.
  - All outstanding counters=0; protocol_error=0.
  - req_ready=0 while reset is asserted.
- FSM has two states:
  - EMPTY: no request held.
  - HELD: l2_req_valid=1; the payload stays stable until l2_req_ready=1.
- load = EMPTY | (HELD & l2_req_ready).
- Eligibility:
  - eligible[i] = req_valid[i] & (~req_rnw[i] | cnt[i] < MAX_OUTSTANDING).
  - A read from a client whose counter is full is masked; writes are never masked.
- Grant:
  - When load=1, grant = first eligible client at or after the client following the last grant, with wrap-around at NUM_REQ-1 to 0.
  - req_ready = grant & {NUM_REQ{load}}; at most one bit is set.
- Transitions:
  - On a grant, the payload is registered, l2_req_id=grant index, and the next state is HELD. Latency is one cycle from the req handshake to l2_req_valid.
  - Pointer advances to grant index+1 only on a grant.
  - HELD & l2_req_ready & no eligible client → EMPTY.
  - HELD & l2_req_ready & an eligible client → stay HELD with the new payload (back-to-back, zero bubble).
- Outstanding counters:
  - cnt[i] increments when client i is granted a read.
  - cnt[i] decrements on l2_rd_valid & l2_rd_last & l2_rd_id==i.
  - Simultaneous increment and decrement on the same client leaves cnt unchanged.
  - Counter width is $clog2(MAX_OUTSTANDING+1); it saturates and never wraps.
- Response routing:
  - Combinational, zero latency.
  - rsp_valid[i] = l2_rd_valid & l2_rd_id==i; rsp_data=l2_rd_data; rsp_last=l2_rd_last.
- Error cases:
  - A beat with l2_rd_id >= NUM_REQ is dropped and sets protocol_error.
  - A last beat to a client with cnt=0 sets protocol_error and leaves the counter at 0.
  - protocol_error is sticky; only reset clears it.
- Reset mid-operation: the held request is discarded and counters are cleared. In-flight L2 responses arriving after reset are flagged by the cnt=0 rule.

Decomposition:
- Shared package (taiga_types) holds:
  - l2_sched_req_t struct: addr, rnw, be, wdata, burst_len, id.
  - Constants L2_SCHED_NUM_REQ and L2_SCHED_MAX_OUTSTANDING, indexed by the existing L1_*_ID constants.
- One sub-module, round_robin_picker: parameterised NUM_REQ; inputs eligible, pointer, load; outputs one-hot grant and grant index. It is purely combinational and reused elsewhere.
- Counters, FSM and routing stay in the top of this block.

Test Plan:
- Clients 0–3 all request reads continuously, l2_req_ready=1 → l2_req_id sequence 0,1,2,3,0,… with no bubble cycles; each req_ready pulse lasts one cycle.
- Client 1 issues a write, l2_req_ready held 0 for 5 cycles → l2_req_valid=1 and payload stable for 5 cycles; no new req_ready; then one-cycle drain.
- MAX_OUTSTANDING=2, client 2 issues 3 reads with no responses → third read blocked (req_ready[2]=0); a client-2 write is still granted; after l2_rd_last with id=2, the third read is granted next cycle.
- 4-beat burst response with l2_rd_id=3 arriving in the same cycle client 3 is granted a read → rsp_valid=4'b1000 on each beat; cnt[3] is unchanged on the last-beat cycle.
- l2_rd_valid=1, l2_rd_last=1, l2_rd_id=0 while cnt[0]=0 → protocol_error=1 and remains 1 until rst=0.
- rst driven low while HELD with cnt={1,2,0,1} → l2_req_valid=0 immediately (asynchronous), all counters 0, first grant after reset goes to client 0.
